// File: rtl/fb_pkg.sv
// Shared types and constants for frame-buffer scan-out.
// Geometry, pixel formats and swap FSM states.
package fb_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 180;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W = 17;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_t;

  // MSB replication so full-scale 565 maps to full-scale 888
  function automatic rgb888_t expand565(rgb565_t p);
    rgb888_t q;
    q.r = {p.r, p.r[4:2]};
    q.g = {p.g, p.g[5:4]};
    q.b = {p.b, p.b[4:2]};
    return q;
  endfunction

endpackage

// File: rtl/fb_swap_ctrl.sv
// Double-buffer swap controller.
// Requests are held until the next frame boundary.
module fb_swap_ctrl
  import fb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic nf,
  input  logic swap_req,
  output logic swap_ack,
  output logic front_buf
);

  swap_state_t state, state_d;
  logic        front_d;
  logic        ack_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SWAP_IDLE;
      front_buf <= 1'b0;
      swap_ack  <= 1'b0;
    end else begin
      state     <= state_d;
      front_buf <= front_d;
      swap_ack  <= ack_d;
    end
  end

  always_comb begin
    state_d = state;
    front_d = front_buf;
    ack_d   = 1'b0;
    unique case (state)
      SWAP_IDLE: begin
        if (swap_req && nf) begin
          front_d = ~front_buf;
          ack_d   = 1'b1;
        end else if (swap_req) begin
          state_d = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        // further requests are absorbed here
        if (nf) begin
          front_d = ~front_buf;
          ack_d   = 1'b1;
          state_d = SWAP_IDLE;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scan-out: screen position to BRAM address,
// read-latency delay line and RGB565 to RGB888 expansion.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int FB_WIDTH    = fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT   = fb_pkg::FB_HEIGHT,
  parameter int SCALE_SHIFT = 2,
  parameter int MIRROR_X    = 1,
  parameter int RD_LATENCY  = 2,
  parameter int ADDR_W      = fb_pkg::FB_ADDR_W
)(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              ad_in,
  input  logic              nf_in,
  input  logic              swap_req_in,
  output logic              swap_ack_out,
  output logic              front_buf_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [15:0]       rd_data_in,
  output logic [7:0]        red_out,
  output logic [7:0]        green_out,
  output logic [7:0]        blue_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              ad_out
);

  localparam int PIXELS = FB_WIDTH * FB_HEIGHT;

  logic [10:0]       x;
  logic [9:0]        y;
  logic [ADDR_W-1:0] xa, ya, col, base, addr_d;
  logic              in_win;

  logic [RD_LATENCY:0]      vld;
  logic [RD_LATENCY:0][2:0] sync_d;
  rgb888_t                  pix;

  fb_swap_ctrl u_swap (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .nf        (nf_in),
    .swap_req  (swap_req_in),
    .swap_ack  (swap_ack_out),
    .front_buf (front_buf_out)
  );

  assign x  = hcount_in >> SCALE_SHIFT;
  assign y  = vcount_in >> SCALE_SHIFT;
  assign xa = ADDR_W'(x);
  assign ya = ADDR_W'(y);

  assign in_win = (xa < ADDR_W'(FB_WIDTH)) &&
                  (ya < ADDR_W'(FB_HEIGHT));

  assign col  = (MIRROR_X != 0) ?
                ADDR_W'(FB_WIDTH - 1) - xa : xa;
  assign base = front_buf_out ? ADDR_W'(PIXELS) : '0;

  // out-of-window reads park at 0; their data is dropped
  assign addr_d = in_win ?
                  base + ya * ADDR_W'(FB_WIDTH) + col : '0;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_addr_out <= '0;
      vld         <= '0;
      sync_d      <= '0;
      pix         <= '0;
      hs_out      <= 1'b0;
      vs_out      <= 1'b0;
      ad_out      <= 1'b0;
    end else begin
      rd_addr_out <= addr_d;
      vld    <= {vld[RD_LATENCY-1:0], in_win & ad_in};
      sync_d <= {sync_d[RD_LATENCY-1:0],
                 {hs_in, vs_in, ad_in}};
      {hs_out, vs_out, ad_out} <= sync_d[RD_LATENCY];
      pix <= vld[RD_LATENCY] ?
             expand565(rgb565_t'(rd_data_in)) : '0;
    end
  end

  assign red_out   = pix.r;
  assign green_out = pix.g;
  assign blue_out  = pix.b;

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout.
// Vector table for mapping/colour, sequences for swap and reset.
module tb_fb_scanout;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hs, vs, ad, nf, swap_req;
  logic        swap_ack, front_buf;
  logic [16:0] rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  red, green, blue;
  logic        hs_o, vs_o, ad_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_scanout dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .hcount_in     (hcount),
    .vcount_in     (vcount),
    .hs_in         (hs),
    .vs_in         (vs),
    .ad_in         (ad),
    .nf_in         (nf),
    .swap_req_in   (swap_req),
    .swap_ack_out  (swap_ack),
    .front_buf_out (front_buf),
    .rd_addr_out   (rd_addr),
    .rd_data_in    (rd_data),
    .red_out       (red),
    .green_out     (green),
    .blue_out      (blue),
    .hs_out        (hs_o),
    .vs_out        (vs_o),
    .ad_out        (ad_o)
  );

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        a;
    logic [15:0] d;
    logic [16:0] addr;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  initial begin
    int acks;
    int hs_cnt;
    logic [2:0] hist [64];

    vecs[0] = '{11'd0,    10'd0,   1'b1, 16'hF800,
                17'd319,   24'hFF0000};
    vecs[1] = '{11'd1279, 10'd719, 1'b1, 16'hFFFF,
                17'd57280, 24'hFFFFFF};
    vecs[2] = '{11'd1280, 10'd719, 1'b1, 16'hFFFF,
                17'd0,     24'h000000};
    vecs[3] = '{11'd100,  10'd100, 1'b0, 16'hFFFF,
                17'd8294,  24'h000000};
    vecs[4] = '{11'd4,    10'd8,   1'b1, 16'h07E0,
                17'd958,   24'h00FF00};
    vecs[5] = '{11'd40,   10'd4,   1'b1, 16'h001F,
                17'd629,   24'h0000FF};
    vecs[6] = '{11'd0,    10'd720, 1'b1, 16'hFFFF,
                17'd0,     24'h000000};
    vecs[7] = '{11'd8,    10'd0,   1'b1, 16'h8410,
                17'd317,   24'h848284};

    rst = 1'b0;
    hcount = '0; vcount = '0;
    hs = 0; vs = 0; ad = 0; nf = 0; swap_req = 0;
    rd_data = '0;
    repeat (3) step();
    chk("reset addr", 32'(rd_addr), 32'd0);
    chk("reset rgb", 32'({red, green, blue}), 32'd0);
    chk("reset sync", 32'({hs_o, vs_o, ad_o}), 32'd0);
    chk("reset front", 32'(front_buf), 32'd0);
    chk("reset ack", 32'(swap_ack), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      hcount  = vecs[i].h;
      vcount  = vecs[i].v;
      ad      = vecs[i].a;
      rd_data = vecs[i].d;
      step();
      chk($sformatf("vec%0d addr", i), 32'(rd_addr),
          32'(vecs[i].addr));
      repeat (3) step();
      chk($sformatf("vec%0d rgb", i),
          32'({red, green, blue}), 32'(vecs[i].rgb));
    end

    // mid-frame swap
    hcount = 0; vcount = 0; ad = 1;
    swap_req = 1; step(); swap_req = 0;
    repeat (3) step();
    chk("pending front", 32'(front_buf), 32'd0);
    chk("pending ack", 32'(swap_ack), 32'd0);
    nf = 1; step(); nf = 0;
    chk("swap front", 32'(front_buf), 32'd1);
    chk("swap ack", 32'(swap_ack), 32'd1);
    step();
    chk("swap ack drop", 32'(swap_ack), 32'd0);
    chk("swap addr", 32'(rd_addr), 32'd57919);

    // request coincident with frame boundary
    swap_req = 1; nf = 1; step();
    swap_req = 0; nf = 0;
    chk("coinc front", 32'(front_buf), 32'd0);
    chk("coinc ack", 32'(swap_ack), 32'd1);
    step();
    chk("coinc ack drop", 32'(swap_ack), 32'd0);

    // three requests, one boundary
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      swap_req = 1; step(); acks += int'(swap_ack);
      swap_req = 0; step(); acks += int'(swap_ack);
    end
    chk("multi pre front", 32'(front_buf), 32'd0);
    nf = 1; step(); acks += int'(swap_ack); nf = 0;
    for (int k = 0; k < 4; k++) begin
      step(); acks += int'(swap_ack);
    end
    chk("multi ack count", 32'(acks), 32'd1);
    chk("multi front", 32'(front_buf), 32'd1);

    // sync alignment
    hs_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      hist[i] = {(i >= 5 && i < 45), (i >= 10 && i < 30),
                 (i >= 8 && i < 52)};
      {hs, vs, ad} = hist[i];
      step();
      hs_cnt += int'(hs_o);
      if (i >= 3)
        chk($sformatf("sync%0d", i),
            32'({hs_o, vs_o, ad_o}), 32'(hist[i-3]));
    end
    {hs, vs, ad} = 3'b000;
    for (int k = 0; k < 6; k++) begin
      step(); hs_cnt += int'(hs_o);
    end
    chk("hs width", 32'(hs_cnt), 32'd40);

    // reset mid-line while a swap is pending
    hcount = 100; vcount = 40; ad = 1; hs = 1;
    rd_data = 16'hFFFF;
    repeat (5) step();
    swap_req = 1; step(); swap_req = 0;
    step();
    rst = 0; step();
    chk("rst addr", 32'(rd_addr), 32'd0);
    chk("rst rgb", 32'({red, green, blue}), 32'd0);
    chk("rst sync", 32'({hs_o, vs_o, ad_o}), 32'd0);
    chk("rst front", 32'(front_buf), 32'd0);
    chk("rst ack", 32'(swap_ack), 32'd0);
    rst = 1;
    repeat (3) step();
    chk("refill red", 32'(red), 32'd0);
    chk("refill hs", 32'(hs_o), 32'd0);
    step();
    chk("refill red on", 32'(red), 32'hFF);
    chk("refill hs on", 32'(hs_o), 32'd1);
    nf = 1; step(); nf = 0;
    chk("drop front", 32'(front_buf), 32'd0);
    chk("drop ack", 32'(swap_ack), 32'd0);
    step();
    chk("drop front2", 32'(front_buf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
